// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared types and helpers for the UART transmit frame sequencer.
//   - state_t   : frame sequencing states
//   - PAR_EVEN / PAR_ODD : encodings of the PAR_TYP input
//   - cnt_width : width of the data-bit index counter
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // A single-bit frame still needs a 1-bit counter, so clamp at 1.
  function automatic int cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter
//   Data shift register and bit-index counter for one UART frame.
//   Ports:
//     clk       in   bit clock
//     rst       in   synchronous active-high reset
//     load      in   capture load_data, clear the bit index
//     shift     in   shift the register right by one
//     step      in   advance the bit index by one
//     load_data in   parallel data word
//     lsb       out  current register LSB (next bit to place on the line)
//     last      out  bit index has reached DATA_WIDTH-1
module uart_tx_shifter
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  lsb,
  output logic                  last
);

  localparam int              CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else begin
      if (shift) sreg <= sreg >> 1;
      if (step)  cnt  <= cnt + CW'(1);
    end
  end

  assign lsb  = sreg[0];
  assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Frame sequencer for the UART transmitter: start bit, DATA_WIDTH data
//   bits LSB first, optional parity bit, stop bit; one bit per CLK cycle.
//   Ports:
//     CLK        in   bit clock
//     RST        in   synchronous active-high reset
//     P_DATA     in   parallel data, sampled on accept
//     Data_Valid in   request strobe (level), honoured in IDLE or STOP
//     PAR_EN     in   1 = append parity bit, sampled on accept
//     PAR_TYP    in   0 = even, 1 = odd, sampled on accept
//     TX_OUT     out  registered serial line, idles high
//     Busy       out  registered, high while a frame is on the line
//     Frame_Done out  registered, high during the stop-bit cycle
//
//   state  | meaning
//   IDLE   | line high, waiting for Data_Valid
//   START  | start bit (0) on the line
//   DATA   | data bit <bit index> on the line
//   PARITY | latched parity bit on the line
//   STOP   | stop bit (1) on the line, Frame_Done high, may accept next frame
//
//   The state register names the bit currently on the line; TX_OUT is
//   loaded on the edge that enters each state, so it is set from the bit
//   the *next* state will show.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Frame_Done
);

  state_t state;
  logic   par_en_q;
  logic   par_bit_q;
  logic   par_calc;
  logic   accept;
  logic   sh_load;
  logic   sh_shift;
  logic   sh_step;
  logic   sh_lsb;
  logic   sh_last;

  assign accept = Data_Valid && ((state == IDLE) || (state == STOP));

  always_comb begin
    par_calc = ^P_DATA;
    case (PAR_TYP)
      PAR_EVEN: par_calc = ^P_DATA;
      PAR_ODD:  par_calc = ~(^P_DATA);
      default:  par_calc = ^P_DATA;
    endcase
  end

  // The START edge moves bit 0 onto the line and pre-shifts so the
  // register LSB is always the bit due next; the index is not advanced
  // there, so it equals the data bit currently on the line.
  assign sh_load  = accept;
  assign sh_shift = (state == START) || ((state == DATA) && !sh_last);
  assign sh_step  = (state == DATA) && !sh_last;

  uart_tx_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .clk       (CLK),
    .rst       (RST),
    .load      (sh_load),
    .shift     (sh_shift),
    .step      (sh_step),
    .load_data (P_DATA),
    .lsb       (sh_lsb),
    .last      (sh_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
    end else begin
      Frame_Done <= 1'b0;
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
            par_en_q  <= PAR_EN;
            par_bit_q <= par_calc;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= sh_lsb;
        end
        DATA: begin
          if (!sh_last) begin
            TX_OUT <= sh_lsb;
          end else if (par_en_q) begin
            state  <= PARITY;
            TX_OUT <= par_bit_q;
          end else begin
            state      <= STOP;
            TX_OUT     <= 1'b1;
            Frame_Done <= 1'b1;
          end
        end
        PARITY: begin
          state      <= STOP;
          TX_OUT     <= 1'b1;
          Frame_Done <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl. The reference model is a queue of the line
// bits still to be shown for the current frame (head = bit on the line now).
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         TX_OUT;
  logic         Busy;
  logic         Frame_Done;

  int total = 0;
  int bad   = 0;
  bit mq[$];

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .Frame_Done (Frame_Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void load_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    int ones = 0;
    mq.delete();
    mq.push_back(1'b0);
    for (int i = 0; i < W; i++) begin
      mq.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) mq.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    mq.push_back(1'b1);
  endfunction

  // One clock edge: advance the model from the inputs the DUT samples,
  // then check all three outputs 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge CLK);
    if (RST) mq.delete();
    else if (Data_Valid && mq.size() <= 1) load_frame(P_DATA, PAR_EN, PAR_TYP);
    else if (mq.size() > 0) void'(mq.pop_front());
    #1;
    chk({tag, ".tx"},   32'(TX_OUT),     32'((mq.size() > 0) ? mq[0] : 1'b1));
    chk({tag, ".busy"}, 32'(Busy),       32'(mq.size() > 0));
    chk({tag, ".done"}, 32'(Frame_Done), 32'(mq.size() == 1));
  endtask

  initial begin
    logic [0:10] exp_a5;
    int fd_cnt;
    int busy_drops;
    exp_a5 = 11'b01010010101;

    RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    step("reset");
    step("reset");
    chk("reset_tx", 32'(TX_OUT), 32'd1);
    chk("reset_busy", 32'(Busy), 32'd0);
    RST = 1'b0;
    step("idle");

    // A5, even parity
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step("a5");
      Data_Valid = 1'b0;
      chk("a5_bits", 32'(TX_OUT), 32'(exp_a5[i]));
      chk("a5_busy", 32'(Busy), 32'd1);
      chk("a5_done", 32'(Frame_Done), 32'(i == 10));
    end
    step("a5_idle");
    chk("a5_busy_fall", 32'(Busy), 32'd0);

    // 01 with odd then even parity
    for (int p = 1; p >= 0; p--) begin
      P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = p[0]; Data_Valid = 1'b1;
      for (int i = 0; i < 11; i++) begin
        step("par01");
        Data_Valid = 1'b0;
        if (i == 9) chk("par01_bit", 32'(TX_OUT), (p == 1) ? 32'd0 : 32'd1);
      end
      step("par01_idle");
    end

    // FF without parity: 10-cycle frame
    P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("ff");
      Data_Valid = 1'b0;
      chk("ff_bits", 32'(TX_OUT), (i == 0) ? 32'd0 : 32'd1);
      chk("ff_done", 32'(Frame_Done), 32'(i == 9));
    end
    step("ff_idle");
    chk("ff_len", 32'(Busy), 32'd0);

    // Back-to-back frames with Data_Valid held
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    fd_cnt = 0; busy_drops = 0;
    for (int i = 0; i < 22; i++) begin
      step("b2b");
      if (i == 0) P_DATA = 8'hC3;
      if (i == 11) begin
        chk("b2b_start", 32'(TX_OUT), 32'd0);
        Data_Valid = 1'b0;
      end
      if (Frame_Done) fd_cnt++;
      if (!Busy) busy_drops++;
    end
    chk("b2b_done_pulses", 32'(fd_cnt), 32'd2);
    chk("b2b_busy_drops", 32'(busy_drops), 32'd0);
    step("b2b_idle");

    // Mid-frame input changes ignored
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step("mid");
      chk("mid_bits", 32'(TX_OUT), 32'(exp_a5[i]));
      Data_Valid = (i >= 2 && i <= 6);
      if (i == 2) begin P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b1; end
    end
    step("mid_idle");
    chk("mid_no_extra", 32'(Busy), 32'd0);

    // Reset during the 4th data bit, then a clean frame
    P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("abort");
      Data_Valid = 1'b0;
    end
    RST = 1'b1;
    step("abort_rst");
    chk("abort_tx", 32'(TX_OUT), 32'd1);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Frame_Done), 32'd0);
    RST = 1'b0;
    P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step("after_abort");
      Data_Valid = 1'b0;
    end
    step("after_abort_idle");

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = W'($urandom);
      PAR_EN     = $urandom_range(0, 1) == 1;
      PAR_TYP    = $urandom_range(0, 1) == 1;
      RST        = ($urandom_range(0, 99) == 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
